// File: rtl/fir_core_m.sv
// rtl/fir_core_m.sv - streaming NTAPS-tap FIR, Q1.15 coefficients, round-half-up and saturate to 16 bits.
// One sample per clock in, one result per accepted sample out, one clock later.

module fir_core_m #(
   parameter int                  NTAPS  = 16,
   parameter logic [NTAPS*16-1:0] COEFFS = {NTAPS{16'sd2048}}
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_data_tvalid,
   output logic        s_axis_data_tready,
   input  logic [15:0] s_axis_data_tdata,
   output logic        m_axis_data_tvalid,
   output logic [15:0] m_axis_data_tdata
);

   localparam int ACC_W = 37;

   logic signed [15:0]      x [NTAPS];
   logic signed [31:0]      prod [NTAPS];
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] rounded;
   logic signed [21:0]      y_full;
   logic signed [15:0]      y_sat;
   logic                    accept;
   logic                    pend;

   assign accept = s_axis_data_tvalid && s_axis_data_tready;

   // Sum is taken over the delay line as it stands after the accepting edge.
   always_comb begin
      acc = '0;
      for (int k = 0; k < NTAPS; k++) begin
         prod[k] = 32'($signed(COEFFS[16*k +: 16])) * 32'(x[k]);
         acc     = acc + ACC_W'(prod[k]);
      end
   end

   assign rounded = acc + ACC_W'(16384);
   assign y_full  = 22'(rounded >>> 15);

   always_comb begin
      if (y_full > 22'sd32767)
         y_sat = 16'sh7fff;
      else if (y_full < -22'sd32768)
         y_sat = 16'sh8000;
      else
         y_sat = y_full[15:0];
   end

   // tready doubles as the internal reset-release flag; pend marks a result owed next edge.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s_axis_data_tready <= 1'b0;
         pend               <= 1'b0;
         m_axis_data_tvalid <= 1'b0;
         m_axis_data_tdata  <= '0;
         for (int k = 0; k < NTAPS; k++)
            x[k] <= '0;
      end else begin
         s_axis_data_tready <= 1'b1;
         pend               <= accept;
         m_axis_data_tvalid <= pend;
         if (pend)
            m_axis_data_tdata <= y_sat;
         if (accept) begin
            x[0] <= s_axis_data_tdata;
            for (int k = 1; k < NTAPS; k++)
               x[k] <= x[k-1];
         end
      end
   end

endmodule

// File: tb/tb_fir_core_m.sv
// tb/tb_fir_core_m.sv - directed bench for fir_core_m with hand-derived expected outputs.
// A second instance with doubled coefficients exercises output saturation.

module tb_fir_core_m;

   logic        aclk;
   logic        aresetn;
   logic        s_valid;
   logic [15:0] s_data;
   logic        tready;
   logic        m_tvalid;
   logic [15:0] m_tdata;
   logic        tready2;
   logic        m2_tvalid;
   logic [15:0] m2_tdata;

   int total = 0;
   int bad   = 0;
   int step  = 0;

   logic        cur_v;
   logic [31:0] cur_d;
   logic        pend_v;
   logic [31:0] pend_d;

   fir_core_m dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .s_axis_data_tvalid (s_valid),
      .s_axis_data_tready (tready),
      .s_axis_data_tdata  (s_data),
      .m_axis_data_tvalid (m_tvalid),
      .m_axis_data_tdata  (m_tdata)
   );

   fir_core_m #(.NTAPS(16), .COEFFS({16{16'sd4096}})) dut_sat (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .s_axis_data_tvalid (s_valid),
      .s_axis_data_tready (tready2),
      .s_axis_data_tdata  (s_data),
      .m_axis_data_tvalid (m2_tvalid),
      .m_axis_data_tdata  (m2_tdata)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step, $signed(obs), $signed(exp));
      end
   endtask

   // Entered and left just after a falling edge.
   task automatic do_reset();
      aresetn = 1'b0;
      s_valid = 1'b1;
      s_data  = 16'd1234;
      #1;
      chk("rst_tready", {31'b0, tready}, 32'd0);
      chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
      chk("rst_tdata", {{16{m_tdata[15]}}, m_tdata}, 32'd0);
      repeat (2) @(negedge aclk);
      chk("rst_hold_tready", {31'b0, tready}, 32'd0);
      chk("rst_hold_tvalid", {31'b0, m_tvalid}, 32'd0);
      aresetn = 1'b1;
      #1;
      chk("rel_tready_pre", {31'b0, tready}, 32'd0);
      @(posedge aclk);
      #1;
      chk("rel_tready_post", {31'b0, tready}, 32'd1);
      chk("rel_tvalid", {31'b0, m_tvalid}, 32'd0);
      @(negedge aclk);
      cur_v  = 1'b0;
      cur_d  = 32'd0;
      pend_v = 1'b0;
      pend_d = 32'd0;
   endtask

   // One clock: check what is visible now, drive a sample, advance the expected pipeline.
   task automatic cyc(input logic v, input logic [15:0] d, input int y);
      step++;
      chk("tready", {31'b0, tready}, 32'd1);
      chk("m_tvalid", {31'b0, m_tvalid}, {31'b0, cur_v});
      chk("m_tdata", {{16{m_tdata[15]}}, m_tdata}, cur_d);
      s_valid = v;
      s_data  = d;
      @(posedge aclk);
      if (pend_v)
         cur_d = pend_d;
      cur_v  = pend_v;
      pend_v = v;
      pend_d = y;
      @(negedge aclk);
   endtask

   task automatic flush();
      cyc(1'b0, 16'h5555, 0);
      cyc(1'b0, 16'h5555, 0);
      cyc(1'b0, 16'h5555, 0);
   endtask

   initial begin
      int n;
      int s;
      int y;
      aresetn = 1'b0;
      s_valid = 1'b0;
      s_data  = 16'd0;
      cur_v   = 1'b0;
      cur_d   = 32'd0;
      pend_v  = 1'b0;
      pend_d  = 32'd0;
      @(negedge aclk);

      // Impulse through the moving average; 1234 held during reset must not leak in.
      do_reset();
      cyc(1'b1, 16'sd32767, 2048);
      for (int i = 1; i <= 20; i++)
         cyc(1'b1, 16'd0, (i < 16) ? 2048 : 0);
      flush();

      // DC step ramps by 1000 per sample up to 16000.
      do_reset();
      for (int i = 1; i <= 20; i++)
         cyc(1'b1, 16'sd16000, ((i < 16) ? i : 16) * 1000);
      flush();

      // Single-sample rounding: 16 -> 1, 8 -> 0.5 -> 1, 7 -> 0, -8 -> -0.5 -> 0, -9 -> -1.
      do_reset();
      cyc(1'b1, 16'sd16, 1);
      flush();
      do_reset();
      cyc(1'b1, 16'sd8, 1);
      flush();
      do_reset();
      cyc(1'b1, 16'sd7, 0);
      flush();
      do_reset();
      cyc(1'b1, -16'sd8, 0);
      flush();
      do_reset();
      cyc(1'b1, -16'sd9, -1);
      flush();

      // Negative full scale settles exactly at -32768.
      do_reset();
      for (int i = 1; i <= 20; i++)
         cyc(1'b1, 16'h8000, ((i < 16) ? i : 16) * -2048);
      flush();

      // Alternating +/-32767: odd fill counts leave one unmatched +32767, full window cancels.
      do_reset();
      for (int i = 1; i <= 24; i++)
         cyc(1'b1, (i % 2 == 1) ? 16'sd32767 : -16'sd32767, ((i < 16) && (i % 2 == 1)) ? 2048 : 0);
      flush();

      // Saturation on the 4096-coefficient instance; the default instance tracks unsaturated.
      do_reset();
      for (int i = 1; i <= 20; i++)
         cyc(1'b1, 16'sd20000, ((i < 16) ? i : 16) * 1250);
      flush();
      chk("sat_pos", {{16{m2_tdata[15]}}, m2_tdata}, 32'd32767);
      chk("sat_tready", {31'b0, tready2}, 32'd1);
      for (int i = 1; i <= 20; i++)
         cyc(1'b1, -16'sd20000, (16 - 2 * ((i < 16) ? i : 16)) * 1250);
      flush();
      chk("sat_neg", {{16{m2_tdata[15]}}, m2_tdata}, 32'hffff_8000);
      chk("sat_tvalid_idle", {31'b0, m2_tvalid}, 32'd0);

      // Gapped ramp with junk data on idle cycles; output is the 16-sample window sum of 1..n.
      do_reset();
      n = 0;
      for (int c = 0; c < 60; c++) begin
         if (c % 3 == 0) begin
            n++;
            s = n * (n + 1) / 2 - ((n > 16) ? (n - 16) * (n - 15) / 2 : 0);
            y = (s * 2048 + 16384) >>> 15;
            cyc(1'b1, 16'(n), y);
         end else begin
            cyc(1'b0, 16'h7abc, 0);
         end
      end
      flush();

      // Reset with a result in flight: it is dropped and history restarts from zero.
      do_reset();
      cyc(1'b1, 16'sd16000, 1000);
      cyc(1'b1, 16'sd16000, 2000);
      do_reset();
      cyc(1'b1, 16'sd16000, 1000);
      cyc(1'b1, 16'sd16000, 2000);
      flush();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
